// File: rtl/div_seq_if.sv
// Request/response bundle for the sequential divider: operation request in,
// status and result out.
interface div_seq_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            flush_i;
  logic            busy_o;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] res_o;

  modport master (
    output start_i, op_i, op_a_i, op_b_i, flush_i,
    input  busy_o, stall_o, done_o, res_o
  );

  modport slave (
    input  start_i, op_i, op_a_i, op_b_i, flush_i,
    output busy_o, stall_o, done_o, res_o
  );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle on operand magnitudes, with divide-by-zero and signed overflow resolved at acceptance.
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_quot;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_is_rem;
  logic [XLEN-1:0]  r_res;

  logic             w_accept;
  logic             w_stall;
  logic             w_done;
  logic             w_signed;
  logic             w_div_zero;
  logic             w_overflow;
  logic [XLEN-1:0]  w_abs_a;
  logic [XLEN-1:0]  w_abs_b;
  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_diff;
  logic [XLEN-1:0]  w_q_fix;
  logic [XLEN-1:0]  w_r_fix;
  logic [XLEN-1:0]  w_result;

  // op_i[0] selects unsigned, op_i[1] selects remainder
  assign w_signed   = ~bus.op_i[0];
  assign w_div_zero = (bus.op_b_i == '0);
  assign w_overflow = w_signed && (bus.op_a_i == MIN_NEG) && (bus.op_b_i == '1);
  assign w_abs_a    = (w_signed && bus.op_a_i[XLEN-1]) ? -bus.op_a_i : bus.op_a_i;
  assign w_abs_b    = (w_signed && bus.op_b_i[XLEN-1]) ? -bus.op_b_i : bus.op_b_i;

  // Shift the next dividend bit into the partial remainder and trial-subtract
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_div};

  assign w_q_fix  = r_neg_q ? -r_quot : r_quot;
  assign w_r_fix  = r_neg_r ? -r_rem  : r_rem;
  assign w_result = r_is_rem ? w_r_fix : w_q_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_stall      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          w_accept     = 1'b1;
          w_stall      = 1'b1;
          w_state_next = (w_div_zero || w_overflow) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        w_stall = 1'b1;
        if (bus.flush_i) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == LAST_IT) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = ~bus.flush_i;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_res    <= '0;
    end else begin
      if (w_accept) begin
        r_is_rem <= bus.op_i[1];
        r_cnt    <= '0;
        r_div    <= w_abs_b;
        // Special cases preload the final answer so DONE needs no fixup
        if (w_div_zero) begin
          r_quot  <= '1;
          r_rem   <= bus.op_a_i;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else if (w_overflow) begin
          r_quot  <= MIN_NEG;
          r_rem   <= '0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else begin
          r_quot  <= w_abs_a;
          r_rem   <= '0;
          r_neg_q <= w_signed && (bus.op_a_i[XLEN-1] ^ bus.op_b_i[XLEN-1]);
          r_neg_r <= w_signed && bus.op_a_i[XLEN-1];
        end
      end else if (r_state == ST_CALC) begin
        if (bus.flush_i) begin
          r_cnt <= '0;
        end else begin
          r_quot <= {r_quot[XLEN-2:0], ~w_diff[XLEN]};
          r_rem  <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
          r_cnt  <= (r_cnt == LAST_IT) ? '0 : r_cnt + CNT_W'(1);
        end
      end
      if (w_done) begin
        r_res <= w_result;
      end
    end
  end

  assign bus.busy_o  = (r_state != ST_IDLE);
  assign bus.stall_o = rst & w_stall;
  assign bus.done_o  = w_done;
  assign bus.res_o   = w_done ? w_result : r_res;

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter: XLEN, DATA_WIDTH (rv32_pkg, 32), operand/result width.
REQ-002 SHALL have port: clk  input  1  main clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start_i  input  1  request a divide/remainder operation.
REQ-005 SHALL have port: op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port: op_a_i  input  XLEN  dividend.
REQ-007 SHALL have port: op_b_i  input  XLEN  divisor.
REQ-008 SHALL have port: flush_i  input  1  abort current operation (pipeline flush).
REQ-009 SHALL have port: busy_o  output  1  operation in progress (state CALC or DONE).
REQ-010 SHALL have port: stall_o  output  1  hold upstream pipeline stages.
REQ-011 SHALL have port: done_o  output  1  one-cycle pulse, res_o valid.
REQ-012 SHALL have port: res_o  output  XLEN  quotient or remainder.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL accept an operation at a rising edge only when state=IDLE, start_i=1 and flush_i=0; operands and op_i SHALL be latched at that edge.
REQ-015 SHALL ignore start_i in CALC and DONE.
REQ-016 SHALL, on acceptance with op_b_i=0, go directly to DONE with: DIV/DIVU -> all-ones; REM/REMU -> op_a_i.
REQ-017 SHALL, on acceptance of DIV/REM with op_a_i=0x80000000 and op_b_i=0xFFFFFFFF, go directly to DONE with: DIV -> 0x80000000; REM -> 0.
REQ-018 SHALL otherwise enter CALC and run a restoring shift-subtract divider on magnitudes, one quotient bit per cycle, for exactly XLEN cycles, using an iteration counter of clog2(XLEN) bits.
REQ-019 SHALL, for DIV/REM, take absolute values of the operands before iterating; the quotient SHALL be negated iff the operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-020 SHALL treat DIVU/REMU operands as raw unsigned bit patterns.
REQ-021 SHALL transition CALC->DONE at the edge that completes the final iteration (counter = XLEN-1).
REQ-022 SHALL assert done_o=1 for exactly the one cycle spent in DONE, with res_o valid in that cycle; DONE->IDLE SHALL follow unconditionally.
REQ-023 SHALL hold res_o stable after DONE until the next DONE or reset.
REQ-024 SHALL use the following latency: a normal op accepted at edge E has done_o high in the cycle after edge E+XLEN (33 cycles for XLEN=32); a special case (REQ-016/017) has done_o high in the cycle after edge E.
REQ-025 SHALL drive stall_o = (state=IDLE and start_i and not flush_i) or state=CALC, combinationally; stall_o SHALL be 0 in DONE so the pipeline advances with the result.
REQ-026 SHALL drive busy_o = (state != IDLE).
REQ-027 SHALL, when flush_i=1 in CALC or DONE, return to IDLE at the next edge, suppress done_o for that operation and leave res_o unchanged.
REQ-028 SHALL give flush_i priority over start_i when both are asserted in IDLE (no acceptance).
REQ-029 SHALL use no arithmetic wider than XLEN+1 bits for the partial remainder.

Reset
REQ-030 SHALL, while rst=0, asynchronously force state=IDLE, counter=0, busy_o=0, stall_o=0, done_o=0, res_o=0 and clear all datapath registers.
REQ-031 SHALL, on reset asserted mid-CALC, discard the operation with no done_o after reset release.
REQ-032 SHALL be ready to accept start_i at the first rising edge after rst deasserts.

Verification
REQ-033 SHALL be verified with: DIVU 100/7 -> done_o 33 cycles after acceptance, res_o=14; stall_o high for cycles 0..32 and low in the done cycle.
REQ-034 SHALL be verified with: DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3); REM same operands -> 0xFFFFFFFF(-1); REMU same operands -> 0x1.
REQ-035 SHALL be verified with: DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, with done_o in the cycle after acceptance.
REQ-036 SHALL be verified with: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0, with 1-cycle latency.
REQ-037 SHALL be verified with: flush_i pulsed at CALC cycle 10 -> IDLE next edge, no done_o, res_o unchanged; a new DIVU 9/3 then returns 3.
REQ-038 SHALL be verified with: rst=0 at CALC cycle 20 -> all outputs 0 immediately; after release no done_o; start_i with flush_i in IDLE -> not accepted.
